spi_fifo_sequencer: RTL and testbench

SPI_FIFO_SEQUENCER -- requirements
Module: spi_fifo_sequencer

---
 rtl/spi_fifo_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_fifo_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_sequencer.sv
// spi_fifo_sequencer: pulls words from a TX FIFO, shifts them out on an SPI
// mode-0 link while shifting the response into an RX FIFO. Consecutive words
// are sent as a burst with chip select held low; a CLK_DIV-cycle gap with
// chip select high follows the last word of a burst.
// Build option: define SPI_SEQ_LSB_FIRST_EN to send and receive LSB first
// (default is MSB first); timing is identical in both builds.
module spi_fifo_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  enable,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
  output logic                  read_fifo_tx,
  input  logic                  full_rx,
  output logic                  write_fifo_rx,
  output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy
);

  // Counter widths hold CLK_DIV and 2*DATA_WIDTH without wrapping.
  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    PUSH,
    GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;     // cycles within a phase
  logic [HALF_W-1:0]       half_q, half_d;   // SCLK half-period index; odd = high
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic                    cs_n_q, cs_n_d;
  logic                    start_ok;

  // Advance the TX register by one bit after the current bit has been sent.
  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_SEQ_LSB_FIRST_EN
    return {1'b0, v[DATA_WIDTH-1:1]};
`else
    return {v[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  // Insert one received bit so the first bit received lands in the first-sent position.
  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b);
`ifdef SPI_SEQ_LSB_FIRST_EN
    return {b, v[DATA_WIDTH-1:1]};
`else
    return {v[DATA_WIDTH-2:0], b};
`endif
  endfunction

  // A new word may start only if there is data to send and room for the reply.
  assign start_ok = enable && !empty_tx && !full_rx;

  // Next-state logic: phase sequencing, bit shifting and chip-select control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    cs_n_d  = cs_n_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = LOAD;
      end
      LOAD: begin
        tx_sr_d = fifo_r_data_tx;
        cs_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          // Even half ends on a rising edge (sample), odd half on a falling edge (advance).
          if (!half_q[0]) rx_sr_d = rx_shift(rx_sr_q, miso);
          else            tx_sr_d = tx_shift(tx_sr_q);
          if (half_q == HALF_LAST) state_d = PUSH;
          else                     half_d  = half_q + HALF_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PUSH: begin
        // Hold here while the RX FIFO is full; chip select stays low.
        if (!full_rx) begin
          if (start_ok) begin
            state_d = LOAD;
          end else begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      GAP: begin
        if (cnt_q == DIV_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign read_fifo_tx   = (state_q == LOAD);
  assign write_fifo_rx  = (state_q == PUSH) && !full_rx;
  assign fifo_w_data_rx = rx_sr_q;
  assign sclk           = (state_q == SHIFT) && half_q[0];
`ifdef SPI_SEQ_LSB_FIRST_EN
  assign mosi           = tx_sr_q[0];
`else
  assign mosi           = tx_sr_q[DATA_WIDTH-1];
`endif
  assign cs_n           = cs_n_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// Testbench for spi_fifo_sequencer (DATA_WIDTH=8, CLK_DIV=2). Stimulus queues
// TX words plus the expected RX words and MOSI bits; a monitor process pops and
// compares them as the DUT strobes write_fifo_rx and raises sclk.
module tb_spi_fifo_sequencer;

  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int LAT = 1 + CD + 2 * CD * DW + 1;   // 36, LOAD..write inclusive
`ifdef SPI_SEQ_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          enable = 1'b0;
  logic          empty_tx = 1'b1;
  logic [DW-1:0] fifo_r_data_tx = '0;
  logic          read_fifo_tx;
  logic          full_rx = 1'b0;
  logic          write_fifo_rx;
  logic [DW-1:0] fifo_w_data_rx;
  logic          sclk, mosi, miso, cs_n, busy;
  logic          loop = 1'b1;
  logic          miso_fix = 1'b0;

  assign miso = loop ? mosi : miso_fix;

  spi_fifo_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .pclk(pclk), .presetn(presetn), .enable(enable), .empty_tx(empty_tx),
    .fifo_r_data_tx(fifo_r_data_tx), .read_fifo_tx(read_fifo_tx),
    .full_rx(full_rx), .write_fifo_rx(write_fifo_rx),
    .fifo_w_data_rx(fifo_w_data_rx), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs_n(cs_n), .busy(busy)
  );

  always #5 pclk = ~pclk;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_bits[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, load_cyc = 0;
  int n_reads = 0, n_writes = 0, n_rises = 0, n_gap = 0, n_csn_rises = 0;
  logic prev_sclk = 1'b0, prev_csn = 1'b1, pop_pending = 1'b0, stalled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_bits(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(LSB ? w[i] : w[DW-1-i]);
  endtask

  task automatic push_word(input logic [DW-1:0] tx, input logic [DW-1:0] rx);
    tx_q.push_back(tx);
    exp_q.push_back(rx);
    push_bits(tx, DW);
  endtask

  // Monitor plus TX FIFO model, evaluated on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge pclk);
      cyc++;
      if (read_fifo_tx) begin
        n_reads++;
        check("rd_while_empty", empty_tx, 0);
        load_cyc = cyc;
      end
      if (write_fifo_rx) begin
        n_writes++;
        check("wr_while_full", full_rx, 0);
        if (exp_q.size() == 0) fail_now("unexpected_write");
        else begin
          check("rx_data", fifo_w_data_rx, exp_q.pop_front());
          if (!stalled) check("latency", cyc - load_cyc + 1, LAT);
        end
      end
      if (sclk && !prev_sclk) begin
        n_rises++;
        if (exp_bits.size() == 0) fail_now("unexpected_sclk_rise");
        else check("mosi_bit", mosi, exp_bits.pop_front());
      end
      if (cs_n && !prev_csn) n_csn_rises++;
      if (cs_n && busy && !read_fifo_tx) n_gap++;
      prev_sclk = sclk;
      prev_csn  = cs_n;
      if (pop_pending && tx_q.size() > 0) void'(tx_q.pop_front());
      pop_pending    = read_fifo_tx;
      empty_tx       = (tx_q.size() == 0);
      fifo_r_data_tx = empty_tx ? '0 : tx_q[0];
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge pclk);
      #1;
      if (n_writes >= target && !busy && tx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_timeout"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_rd"}, read_fifo_tx, 0);
    check({tag, "_wr"}, write_fifo_rx, 0);
    check({tag, "_data"}, fifo_w_data_rx, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic stimulus();
    int b_rd, b_wr, b_rise, b_gap, b_csn;
    bit ok;
    repeat (3) @(posedge pclk);
    #1 check_reset_outputs("reset");
    presetn = 1'b1;
    repeat (2) @(posedge pclk);

    // Single word 0xA5 with loopback.
    #2;
    b_rd = n_reads; b_wr = n_writes; b_rise = n_rises; b_gap = n_gap; b_csn = n_csn_rises;
    push_word(8'hA5, 8'hA5);
    enable = 1'b1;
    wait_done(b_wr + 1, 200, "single");
    enable = 1'b0;
    check("single_reads", n_reads - b_rd, 1);
    check("single_writes", n_writes - b_wr, 1);
    check("single_rises", n_rises - b_rise, 8);
    check("single_gap_cycles", n_gap - b_gap, 2);
    check("single_cs_rises", n_csn_rises - b_csn, 1);
    check("single_bits_left", exp_bits.size(), 0);

    // Burst of two words: chip select stays low, one gap at the end.
    repeat (3) @(posedge pclk);
    #2;
    b_rd = n_reads; b_wr = n_writes; b_rise = n_rises; b_gap = n_gap; b_csn = n_csn_rises;
    push_word(8'h3C, 8'h3C);
    push_word(8'hC3, 8'hC3);
    enable = 1'b1;
    wait_done(b_wr + 2, 300, "burst");
    enable = 1'b0;
    check("burst_reads", n_reads - b_rd, 2);
    check("burst_writes", n_writes - b_wr, 2);
    check("burst_rises", n_rises - b_rise, 16);
    check("burst_gap_cycles", n_gap - b_gap, 2);
    check("burst_cs_rises", n_csn_rises - b_csn, 1);
    check("burst_rx_left", exp_q.size(), 0);

    // RX full during the word: hold in PUSH until released, then push.
    repeat (3) @(posedge pclk);
    #2;
    b_wr = n_writes;
    stalled = 1'b1;
    push_word(8'h5A, 8'h5A);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge pclk);
      #1;
      if (sclk) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("stall_no_sclk_timeout");
    full_rx = 1'b1;
    repeat (40) @(posedge pclk);
    #1;
    check("stall_busy", busy, 1);
    check("stall_cs_n", cs_n, 0);
    check("stall_sclk", sclk, 0);
    check("stall_wr", write_fifo_rx, 0);
    check("stall_no_push", n_writes - b_wr, 0);
    full_rx = 1'b0;
    wait_done(b_wr + 1, 100, "stall");
    enable = 1'b0;
    stalled = 1'b0;
    check("stall_writes", n_writes - b_wr, 1);
    check("stall_rx_left", exp_q.size(), 0);

    // Reset at the fourth bit of a word: word discarded, next word clean.
    repeat (3) @(posedge pclk);
    #2;
    b_wr = n_writes; b_rise = n_rises;
    tx_q.push_back(8'h96);
    push_bits(8'h96, 4);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge pclk);
      #1;
      if (n_rises - b_rise >= 4) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("rst_word_timeout");
    presetn = 1'b0;
    #2 check_reset_outputs("midrst");
    enable = 1'b0;
    repeat (3) @(posedge pclk);
    #2 presetn = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    check("midrst_no_push", n_writes - b_wr, 0);
    check("midrst_idle", busy, 0);
    b_rd = n_reads;
    push_word(8'h69, 8'h69);
    enable = 1'b1;
    wait_done(b_wr + 1, 200, "after_rst");
    enable = 1'b0;
    check("after_rst_reads", n_reads - b_rd, 1);
    check("after_rst_writes", n_writes - b_wr, 1);

    // Word 0x01 with miso tied high: RX must be all ones.
    repeat (3) @(posedge pclk);
    #2;
    b_wr = n_writes; b_rise = n_rises;
    loop = 1'b0;
    miso_fix = 1'b1;
    push_word(8'h01, 8'hFF);
    enable = 1'b1;
    wait_done(b_wr + 1, 200, "ones");
    enable = 1'b0;
    loop = 1'b1;
    check("ones_rises", n_rises - b_rise, 8);
    check("ones_rx_left", exp_q.size(), 0);
    check("ones_bits_left", exp_bits.size(), 0);
    repeat (4) @(posedge pclk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (20000) @(posedge pclk);
        fail_now("global_timeout");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
